// File: rtl/ppb_host_master.sv
// PMOD probe bus initiator: header/shift framing for I/O exchange, project-ID read and target reset.
// Latency: done at accept+1+P*2*CLK_DIV cycles (P = 1+max(IN,OUT) exchange, 9 ID read, 4 reset).
// Backpressure: start is honoured only in IDLE; requests while busy (or cmd=11) are dropped.
module ppb_host_master #(
    parameter int          INPUT_BLOCKS  = 20,
    parameter int          OUTPUT_BLOCKS = 40,
    parameter int          CLK_DIV       = 2,
    parameter logic [22:0] EXPECTED_ID   = 23'h31c748
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 cmd,
    input  logic [3*INPUT_BLOCKS-1:0]  tx_data,
    output logic [3*OUTPUT_BLOCKS-1:0] rx_data,
    output logic [22:0]                project_id,
    output logic                       id_match,
    output logic                       busy,
    output logic                       done,
    output logic                       pmod_rst,
    output logic                       pmod_bus_clk,
    output logic                       pmod_bus_control,
    output logic [2:0]                 pmod_bus_poti,
    input  logic [2:0]                 pmod_bus_pito
);

    localparam int TXW    = 3 * INPUT_BLOCKS;
    localparam int RXW    = 3 * OUTPUT_BLOCKS;
    localparam int NSHIFT = (INPUT_BLOCKS > OUTPUT_BLOCKS) ? INPUT_BLOCKS : OUTPUT_BLOCKS;
    localparam int NMAX   = (NSHIFT > 8) ? NSHIFT : 8;
    localparam int BW     = $clog2(NMAX + 1);
    localparam int PW     = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    localparam logic [PW-1:0] PH_HI     = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_XCHG = BW'(NSHIFT - 1);
    localparam logic [BW-1:0] LAST_ID   = BW'(7);
    localparam logic [BW-1:0] LAST_RST  = BW'(3);
    localparam logic [BW-1:0] RX_BLKS   = BW'(OUTPUT_BLOCKS);

    localparam logic [1:0] CMD_XCHG = 2'b00;
    localparam logic [1:0] CMD_ID   = 2'b01;
    localparam logic [1:0] CMD_RST  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_HDR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [TXW-1:0]   tx_q, tx_d;
    logic [RXW-1:0]   rx_sh_q, rx_sh_d;
    logic [23:0]      id_sh_q, id_sh_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [BW-1:0]    blk_q, blk_d;
    logic [RXW-1:0]   rx_data_q, rx_data_d;
    logic [22:0]      project_id_q, project_id_d;
    logic             id_match_q, id_match_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             prst_q, prst_d;
    logic             bclk_q, bclk_d;
    logic             ctrl_q, ctrl_d;
    logic [2:0]       poti_q, poti_d;

    logic [PW-1:0]    ph_nxt;
    logic [BW-1:0]    last_blk;
    logic             fin;

    // Next-state logic: bus phase sequencing, pito capture and command completion
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        tx_d         = tx_q;
        rx_sh_d      = rx_sh_q;
        id_sh_d      = id_sh_q;
        ph_d         = ph_q;
        blk_d        = blk_q;
        rx_data_d    = rx_data_q;
        project_id_d = project_id_q;
        id_match_d   = id_match_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        prst_d       = prst_q;
        bclk_d       = bclk_q;
        ctrl_d       = ctrl_q;
        poti_d       = poti_q;
        fin          = 1'b0;
        ph_nxt       = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
        last_blk     = (cmd_q == CMD_ID) ? LAST_ID : LAST_XCHG;

        case (state_q)
            S_IDLE: begin
                if (start && (cmd != 2'b11)) begin
                    state_d = (cmd == CMD_RST) ? S_RST : S_HDR;
                    cmd_d   = cmd;
                    // Only the exchange drives data; other commands shift out zeros.
                    tx_d    = (cmd == CMD_XCHG) ? tx_data : '0;
                    busy_d  = 1'b1;
                    ph_d    = '0;
                    blk_d   = '0;
                    bclk_d  = 1'b0;
                    prst_d  = (cmd == CMD_RST);
                    ctrl_d  = (cmd != CMD_RST);
                    poti_d  = (cmd == CMD_XCHG) ? 3'b001 :
                              (cmd == CMD_ID)   ? 3'b010 : 3'b000;
                end
            end
            S_RST, S_HDR, S_SHIFT: begin
                ph_d   = ph_nxt;
                bclk_d = (ph_nxt >= PH_HI);
                // Sample the target at the end of the first high cycle of the bus clock.
                if ((state_q == S_SHIFT) && (ph_q == PH_HI)) begin
                    if (cmd_q == CMD_XCHG) begin
                        if (blk_q < RX_BLKS) begin
                            rx_sh_d = {pmod_bus_pito, rx_sh_q[RXW-1:3]};
                        end
                    end else begin
                        id_sh_d = {pmod_bus_pito, id_sh_q[23:3]};
                    end
                end
                if (ph_q == PH_LAST) begin
                    case (state_q)
                        S_HDR: begin
                            state_d = S_SHIFT;
                            blk_d   = '0;
                            ctrl_d  = 1'b0;
                            poti_d  = tx_q[2:0];
                            tx_d    = tx_q >> 3;
                        end
                        S_SHIFT: begin
                            if (blk_q == last_blk) begin
                                fin = 1'b1;
                            end else begin
                                blk_d  = blk_q + BW'(1);
                                poti_d = tx_q[2:0];
                                tx_d   = tx_q >> 3;
                            end
                        end
                        S_RST: begin
                            if (blk_q == LAST_RST) begin
                                fin = 1'b1;
                            end else begin
                                blk_d = blk_q + BW'(1);
                            end
                        end
                        default: begin
                            fin = 1'b0;
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion: publish results atomically with the done pulse, idle the bus.
        if (fin) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            prst_d  = 1'b0;
            bclk_d  = 1'b0;
            ctrl_d  = 1'b0;
            poti_d  = 3'b000;
            ph_d    = '0;
            if (cmd_q == CMD_XCHG) begin
                rx_data_d = rx_sh_d;
            end
            if (cmd_q == CMD_ID) begin
                project_id_d = id_sh_d[22:0];
                id_match_d   = (id_sh_d[22:0] == EXPECTED_ID);
            end
        end
    end

    // State and registered outputs; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            tx_q         <= '0;
            rx_sh_q      <= '0;
            id_sh_q      <= '0;
            ph_q         <= '0;
            blk_q        <= '0;
            rx_data_q    <= '0;
            project_id_q <= '0;
            id_match_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            prst_q       <= 1'b0;
            bclk_q       <= 1'b0;
            ctrl_q       <= 1'b0;
            poti_q       <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            tx_q         <= tx_d;
            rx_sh_q      <= rx_sh_d;
            id_sh_q      <= id_sh_d;
            ph_q         <= ph_d;
            blk_q        <= blk_d;
            rx_data_q    <= rx_data_d;
            project_id_q <= project_id_d;
            id_match_q   <= id_match_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            prst_q       <= prst_d;
            bclk_q       <= bclk_d;
            ctrl_q       <= ctrl_d;
            poti_q       <= poti_d;
        end
    end

    assign rx_data          = rx_data_q;
    assign project_id       = project_id_q;
    assign id_match         = id_match_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pmod_rst         = prst_q;
    assign pmod_bus_clk     = bclk_q;
    assign pmod_bus_control = ctrl_q;
    assign pmod_bus_poti    = poti_q;

endmodule

// File: tb/tb_ppb_host_master.sv
// Bench for ppb_host_master: behavioural PPB target plus per-scenario checks.
// Expected values come from block-level arithmetic on tx/reply vectors.
// Every wait on the DUT is bounded; a timeout shows up as a failed comparison.
module tb_ppb_host_master;

    localparam int IB   = 20;
    localparam int OB   = 40;
    localparam int CD   = 2;
    localparam int NS   = (IB > OB) ? IB : OB;
    localparam int XLAT = 1 + (1 + NS) * 2 * CD;
    localparam int ILAT = 1 + 9 * 2 * CD;
    localparam int RLAT = 1 + 4 * 2 * CD;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      cmd = 2'b00;
    logic [3*IB-1:0] tx_data = '0;
    logic [3*OB-1:0] rx_data;
    logic [22:0]     project_id;
    logic            id_match, busy, done;
    logic            pmod_rst, pmod_bus_clk, pmod_bus_control;
    logic [2:0]      pmod_bus_poti;
    logic [2:0]      pito = 3'b000;

    int total = 0;
    int bad   = 0;

    ppb_host_master dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cmd              (cmd),
        .tx_data          (tx_data),
        .rx_data          (rx_data),
        .project_id       (project_id),
        .id_match         (id_match),
        .busy             (busy),
        .done             (done),
        .pmod_rst         (pmod_rst),
        .pmod_bus_clk     (pmod_bus_clk),
        .pmod_bus_control (pmod_bus_control),
        .pmod_bus_poti    (pmod_bus_poti),
        .pmod_bus_pito    (pito)
    );

    always #5 clk = ~clk;

    // Target model: latches poti on rising bus clock, presents the next reply block on falling.
    logic [2:0] reply [0:OB-1];
    logic [2:0] seen_q [$];
    logic [2:0] hdr_poti = 3'b000;
    int         nxt = OB;

    always @(pmod_bus_clk) begin
        if (pmod_bus_clk) begin
            if (pmod_bus_control) begin
                hdr_poti = pmod_bus_poti;
                nxt = 0;
            end else begin
                seen_q.push_back(pmod_bus_poti);
            end
        end else begin
            pito = (nxt >= 0 && nxt < OB) ? reply[nxt] : 3'b000;
            nxt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to its done pulse, recording what was seen.
    task automatic run_cmd(input logic [1:0] c_in, input logic [3*IB-1:0] tx_in, input int inj_at,
                           output int lat, output int busy_bad, output int rst_cyc,
                           output int rst_rises, output int ctrl_in_rst);
        logic prev_clk;
        lat = -1; busy_bad = 0; rst_cyc = 0; rst_rises = 0; ctrl_in_rst = 0;
        seen_q.delete();
        start = 1'b1; cmd = c_in; tx_data = tx_in;
        step();
        start = 1'b0;
        prev_clk = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                lat = c;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            if (pmod_rst) begin
                rst_cyc++;
                if (pmod_bus_control) ctrl_in_rst++;
                if (pmod_bus_clk && !prev_clk) rst_rises++;
            end
            prev_clk = pmod_bus_clk;
            if (c == inj_at) begin
                start = 1'b1; cmd = 2'b00; tx_data = ~tx_in;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    function automatic logic [3*NS-1:0] exp_poti(input logic [3*IB-1:0] tx);
        logic [3*NS-1:0] v = '0;
        for (int k = 0; k < NS; k++) v[3*k +: 3] = (k < IB) ? tx[3*k +: 3] : 3'b000;
        return v;
    endfunction

    function automatic logic [3*NS-1:0] obs_poti();
        logic [3*NS-1:0] v = '0;
        for (int k = 0; k < seen_q.size() && k < NS; k++) v[3*k +: 3] = seen_q[k];
        return v;
    endfunction

    function automatic logic [3*OB-1:0] exp_rx();
        logic [3*OB-1:0] v = '0;
        for (int k = 0; k < OB; k++) v[3*k +: 3] = reply[k];
        return v;
    endfunction

    task automatic test_reset();
        int busy_n = 0, done_n = 0, clk_n = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        total++;
        if ({rx_data, project_id, id_match} !== '0) begin
            bad++; $display("FAIL reset_results: got rx=%0h id=%0h match=%0b want 0", rx_data, project_id, id_match);
        end
        total++;
        if ({busy, done, pmod_rst, pmod_bus_clk, pmod_bus_control, pmod_bus_poti} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000000",
                {busy, done, pmod_rst, pmod_bus_clk, pmod_bus_control, pmod_bus_poti});
        end
        rst = 1'b0;
        step();
        start = 1'b1; cmd = 2'b11; tx_data = '1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            busy_n += int'(busy); done_n += int'(done); clk_n += int'(pmod_bus_clk);
            step();
        end
        total++;
        if (busy_n != 0 || done_n != 0 || clk_n != 0) begin
            bad++; $display("FAIL reserved_cmd: got busy=%0d done=%0d clk_hi=%0d want 0/0/0", busy_n, done_n, clk_n);
        end
    endtask

    task automatic test_exchange(input logic [3*IB-1:0] tx, input bit rnd);
        int lat, bb, rc, rr, cs;
        logic [3*OB-1:0] erx;
        logic [22:0]     pid;
        for (int k = 0; k < OB; k++) reply[k] = rnd ? 3'($urandom_range(0, 7)) : 3'(k % 8);
        erx = exp_rx();
        pid = project_id;
        run_cmd(2'b00, tx, -1, lat, bb, rc, rr, cs);
        total++;
        if (lat != XLAT) begin bad++; $display("FAIL xchg_latency: got %0d want %0d", lat, XLAT); end
        total++;
        if (bb != 0) begin bad++; $display("FAIL xchg_busy: got %0d bad cycles want 0", bb); end
        total++;
        if (hdr_poti !== 3'b001) begin bad++; $display("FAIL xchg_header: got %b want 001", hdr_poti); end
        total++;
        if (seen_q.size() != NS) begin bad++; $display("FAIL xchg_periods: got %0d want %0d", seen_q.size(), NS); end
        total++;
        if (obs_poti() !== exp_poti(tx)) begin
            bad++; $display("FAIL xchg_poti: got %h want %h", obs_poti(), exp_poti(tx));
        end
        total++;
        if (rx_data !== erx) begin bad++; $display("FAIL xchg_rx: got %h want %h", rx_data, erx); end
        total++;
        if (project_id !== pid) begin bad++; $display("FAIL xchg_id_hold: got %h want %h", project_id, pid); end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL xchg_done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_id_read(input logic [23:0] id24);
        int lat, bb, rc, rr, cs;
        logic [3*OB-1:0] rx_before;
        logic [23:0]     ov;
        for (int k = 0; k < OB; k++) reply[k] = (k < 8) ? id24[3*k +: 3] : 3'b000;
        rx_before = rx_data;
        run_cmd(2'b01, '1, -1, lat, bb, rc, rr, cs);
        ov = '0;
        for (int k = 0; k < seen_q.size() && k < 8; k++) ov[3*k +: 3] = seen_q[k];
        total++;
        if (lat != ILAT) begin bad++; $display("FAIL id_latency: got %0d want %0d", lat, ILAT); end
        total++;
        if (hdr_poti !== 3'b010 || seen_q.size() != 8 || ov !== 24'h0) begin
            bad++; $display("FAIL id_bus: got hdr=%b n=%0d poti=%h want 010 8 0", hdr_poti, seen_q.size(), ov);
        end
        total++;
        if (project_id !== id24[22:0]) begin bad++; $display("FAIL id_value: got %h want %h", project_id, id24[22:0]); end
        total++;
        if (id_match !== (id24[22:0] == 23'h31c748)) begin
            bad++; $display("FAIL id_match: got %b want %b", id_match, (id24[22:0] == 23'h31c748));
        end
        total++;
        if (rx_data !== rx_before) begin bad++; $display("FAIL id_rx_hold: got %h want %h", rx_data, rx_before); end
        step();
    endtask

    task automatic test_target_reset();
        int lat, bb, rc, rr, cs;
        run_cmd(2'b10, '1, -1, lat, bb, rc, rr, cs);
        total++;
        if (lat != RLAT) begin bad++; $display("FAIL trst_latency: got %0d want %0d", lat, RLAT); end
        total++;
        if (rc != 4 * 2 * CD) begin bad++; $display("FAIL trst_width: got %0d want %0d", rc, 4 * 2 * CD); end
        total++;
        if (rr != 4) begin bad++; $display("FAIL trst_edges: got %0d want 4", rr); end
        total++;
        if (cs != 0 || pmod_rst !== 1'b0) begin
            bad++; $display("FAIL trst_lines: got ctrl_cycles=%0d rst_at_done=%b want 0 0", cs, pmod_rst);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat, bb, rc, rr, cs;
        logic [3*IB-1:0] tx;
        logic [3*OB-1:0] erx;
        tx = {28'($urandom), 32'($urandom)};
        for (int k = 0; k < OB; k++) reply[k] = 3'($urandom_range(0, 7));
        erx = exp_rx();
        run_cmd(2'b00, tx, 10, lat, bb, rc, rr, cs);
        total++;
        if (lat != XLAT) begin bad++; $display("FAIL busy_latency: got %0d want %0d", lat, XLAT); end
        total++;
        if (obs_poti() !== exp_poti(tx) || rx_data !== erx) begin
            bad++; $display("FAIL busy_data: got rx=%h want %h", rx_data, erx);
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL busy_ghost: got busy=%b done=%b want 0 0", busy, done);
        end
        tx = {28'($urandom), 32'($urandom)};
        for (int k = 0; k < OB; k++) reply[k] = 3'($urandom_range(0, 7));
        erx = exp_rx();
        run_cmd(2'b00, tx, -1, lat, bb, rc, rr, cs);
        total++;
        if (lat != XLAT || bb != 0) begin bad++; $display("FAIL b2b_latency: got %0d busy_bad=%0d want %0d 0", lat, bb, XLAT); end
        total++;
        if (rx_data !== erx) begin bad++; $display("FAIL b2b_rx: got %h want %h", rx_data, erx); end
        step();
    endtask

    task automatic test_abort();
        int done_n = 0, busy_n = 0;
        for (int k = 0; k < OB; k++) reply[k] = 3'($urandom_range(0, 7));
        start = 1'b1; cmd = 2'b00; tx_data = {28'($urandom), 32'($urandom)};
        step();
        start = 1'b0;
        for (int c = 1; c < 50; c++) step();
        rst = 1'b1;
        step();
        total++;
        if ({pmod_rst, pmod_bus_clk, pmod_bus_control, pmod_bus_poti} !== 6'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_bus: got %b busy=%b want 000000 0",
                {pmod_rst, pmod_bus_clk, pmod_bus_control, pmod_bus_poti}, busy);
        end
        total++;
        if (rx_data !== '0) begin bad++; $display("FAIL abort_rx: got %h want 0", rx_data); end
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            done_n += int'(done); busy_n += int'(busy);
            step();
        end
        total++;
        if (done_n != 0 || busy_n != 0) begin
            bad++; $display("FAIL abort_quiet: got done=%0d busy=%0d want 0 0", done_n, busy_n);
        end
    endtask

    initial begin
        for (int k = 0; k < OB; k++) reply[k] = 3'b000;
        test_reset();
        test_exchange(60'h0123456789ABCDE, 1'b0);
        for (int i = 0; i < 3; i++) test_exchange({28'($urandom), 32'($urandom)}, 1'b1);
        test_id_read(24'h31c748);
        test_id_read(24'h000001);
        test_id_read({1'b1, 23'h31c748});
        test_id_read(24'($urandom));
        test_target_reset();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppb_host_master.md
Name: ppb_host_master

Overview:
- Probe-side initiator of the PMOD probe bus (PPB); drives the target board's PPB physical-layer responder over pmod_rst, pmod_bus_clk, pmod_bus_control and pmod_bus_poti, and samples pmod_bus_pito.
- Runs three commands: a full I/O exchange (shift device inputs out, capture device outputs), a project-ID read, and a target reset.
- Sits in the host/probe FPGA between the debug controller and the PMOD header.

Parameters:
INPUT_BLOCKS, 20, 3-bit blocks sent to the target per exchange (tx width 3*INPUT_BLOCKS)
OUTPUT_BLOCKS, 40, 3-bit blocks captured from the target per exchange (rx width 3*OUTPUT_BLOCKS)
CLK_DIV, 2, clk cycles per bus-clock half period; must be >= 1
EXPECTED_ID, 23'h31c748, project ID the read result is compared against

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  command request; accepted only in IDLE
cmd  in  2  00 exchange, 01 read ID, 10 target reset, 11 reserved
tx_data  in  3*INPUT_BLOCKS  device input vector; sampled on the accept cycle
rx_data  out  3*OUTPUT_BLOCKS  captured device outputs; updated atomically with done
project_id  out  23  last ID read
id_match  out  1  project_id == EXPECTED_ID; valid after the first ID read
busy  out  1  high from the accept cycle+1 until done
done  out  1  one-cycle pulse at command completion
pmod_rst  out  1  target reset line
pmod_bus_clk  out  1  bus clock
pmod_bus_control  out  1  header/frame marker
pmod_bus_poti  out  3  probe-out/target-in data
pmod_bus_pito  in  3  probe-in/target-out data

Behaviour:
- Reset: all outputs are 0, including rx_data, project_id and id_match. State goes to IDLE and the phase counter clears. rst asserted mid-command aborts it on the next edge: bus lines go idle (all 0), busy=0, no done pulse, and captured data is discarded.
- Bus period: 2*CLK_DIV clk cycles. pmod_bus_clk is low for the first CLK_DIV cycles and high for the second CLK_DIV cycles.
- Bus timing: control and poti change only on the cycle pmod_bus_clk goes low. pito is registered on the cycle pmod_bus_clk goes high. In IDLE, pmod_bus_clk stays 0.
- States: IDLE -> (RST | HDR) -> SHIFT -> DONE -> IDLE.
- IDLE, start=1, cmd in {00,01,10}:
  - Latch cmd and tx_data.
  - First bus period begins on the next cycle.
  - busy is asserted that same next cycle.
- IDLE, start=1, cmd=11: ignored; no state change.
- start is ignored in every state other than IDLE.
- HDR: one period with control=1. poti=3'b001 for an exchange, 3'b010 for an ID read.
- SHIFT for exchange: N = max(INPUT_BLOCKS, OUTPUT_BLOCKS) periods, control=0.
  - Period k: poti = tx_data[3k+2:3k] if k < INPUT_BLOCKS, else 3'b000.
  - pito sampled in period k fills rx bits [3k+2:3k] for k < OUTPUT_BLOCKS.
  - Block 0 is the LSB block in both directions.
- SHIFT for ID read: 8 periods, poti=0. pito blocks are assembled LSB-first into 24 bits; project_id = bits[22:0]; bit 23 is ignored.
- RST (cmd 10): 4 periods with pmod_rst=1 and pmod_bus_clk toggling normally, control=0, poti=0. pmod_rst drops on the cycle DONE is entered.
- DONE: lasts one cycle.
  - done=1, busy=0.
  - rx_data is loaded from the shift register (exchange only); otherwise it holds.
  - project_id and id_match are loaded (ID read only).
  - Returns to IDLE; a start in the cycle after done is accepted.
- Latency: start accepted at cycle t gives done at t+1+P*2*CLK_DIV, where P = periods for the command (exchange 1+N, ID 9, reset 4). With defaults the exchange completes at t+165.
- rx_data and project_id never show partial results.

Test Plan:
- Reset: assert rst 3 cycles -> all outputs 0, pmod_bus_clk static 0; start with cmd=11 -> busy stays 0, no done.
- Exchange, defaults: tx_data = 60'h0123456789ABCDE, and the target model returns block k = k mod 8 -> poti blocks match tx_data LSB-first for k < 20 and are 0 for k = 20..39; rx_data block k = k mod 8; done exactly at t+165; busy high t+1..t+164.
- ID read: model returns 24'h31c748 -> project_id=23'h31c748, id_match=1. Repeat with 24'h000001 -> id_match=0.
- Busy protection: start with cmd=00 at t+10 during an exchange -> ignored, a single done, rx_data unchanged from the first exchange. Back-to-back start at the done+1 cycle -> accepted.
- Abort: rst at cycle t+50 of an exchange -> next cycle all bus lines 0, busy=0, rx_data=0, no done within 200 cycles.
- Target reset, CLK_DIV=2: pmod_rst high for 16 clk cycles containing exactly 4 rising pmod_bus_clk edges; control=0 throughout; done at t+17.
